ysyx_220053_trap_seq: RTL
=========================

// Module: ysyx_220053_trap_seq
// PURPOSE
//   Trap sequencer sitting directly upstream of the CSR file. On ecall or a timer
//   interrupt it serialises the writes mepc then mcause through the CSR single
//   write port, then redirects fetch to mtvec. On mret it redirects fetch to mepc.
//   It stalls the core while a sequence is in flight. The CSR file's own ecall
//   shortcut input is tied 0 in this configuration.
// PARAMETERS
//   XLEN        64                      data/PC width
//   ECALL_CAUSE 64'd11                  mcause value for environment call from M-mode
//   TIMER_CAUSE 64'h8000_0000_0000_0007 mcause value for machine timer interrupt
// PORTS
//   clk           in   1     core clock, all state updates on posedge
//   rst_n         in   1     synchronous reset, active-low
//   inst_valid_i  in   1     an instruction is present in the execute slot this cycle
//   pc_i          in   XLEN  PC of the instruction in the execute slot
//   ecall_i       in   1     decoded ecall, qualified by inst_valid_i
//   mret_i        in   1     decoded mret, qualified by inst_valid_i
//   irq_timer_i   in   1     level timer interrupt request
//   irq_en_i      in   1     global interrupt enable (mstatus.MIE)
//   mtvec_i       in   XLEN  current mtvec read from the CSR file
//   mepc_i        in   XLEN  current mepc read from the CSR file
//   csr_wen_o     out  1     CSR write enable to the CSR file
//   csr_id_o      out  12    CSR address; 0x341 mepc, 0x342 mcause, otherwise 0
//   csr_op_o      out  3     CSR op; always 3'b000 (plain write)
//   csr_data_o    out  XLEN  CSR write data
//   kill_o        out  1     squash the execute-slot instruction (no regfile/mem commit)
//   stall_o       out  1     freeze fetch/decode/PC
//   redirect_o    out  1     one-cycle pulse: load redirect_pc_o into PC
//   redirect_pc_o out  XLEN  redirect target
// BEHAVIOUR
//   - FSM states: IDLE, WR_EPC, WR_CAUSE, REDIR.
//   - Reset (rst_n=0 at a posedge): state goes to IDLE; epc_q and cause_q are cleared to 0.
//     All outputs are 0 while in IDLE with no event.
//   - Event priority in IDLE (only when inst_valid_i=1):
//     1. timer: irq_timer_i & irq_en_i
//     2. ecall_i
//     3. mret_i
//   - Trap taken (timer or ecall) at cycle T:
//     - kill_o=1 and stall_o=1 combinationally in T.
//     - epc_q<=pc_i; cause_q<=TIMER_CAUSE or ECALL_CAUSE; next state WR_EPC.
//   - WR_EPC (T+1): csr_wen_o=1, csr_id_o=0x341, csr_data_o=epc_q, stall_o=1; next WR_CAUSE.
//   - WR_CAUSE (T+2): csr_wen_o=1, csr_id_o=0x342, csr_data_o=cause_q, stall_o=1; next REDIR.
//   - REDIR (T+3):
//     - redirect_o=1, redirect_pc_o={mtvec_i[XLEN-1:2],2'b00} (direct mode only), stall_o=0.
//     - Next state IDLE. Events are not accepted in REDIR.
//   - mret in IDLE at T: combinational redirect_o=1, redirect_pc_o=mepc_i, kill_o=0, stall_o=0.
//     No state change. Total latency 0 cycles.
//   - While not in IDLE, ecall_i/mret_i/irq_timer_i are ignored. A level irq still asserted
//     is re-evaluated on the first IDLE cycle with inst_valid_i=1.
//   - inst_valid_i=0: no event is taken, including a pending interrupt.
//   - csr_data_o=0 and csr_id_o=0 whenever csr_wen_o=0.
//   - Reset mid-sequence: aborts at that posedge. Writes already issued stand; no further
//     writes and no redirect.
// TESTING
//   - ecall at pc=0x8000_0010, mtvec=0x8000_0104 -> kill@T; T+1 write 0x341=0x8000_0010;
//     T+2 write 0x342=11; T+3 redirect to 0x8000_0104; stall high T..T+2 only.
//   - mret with mepc=0x8000_0014 -> same-cycle redirect to 0x8000_0014; no CSR write; no stall.
//   - irq_timer=1, irq_en=1, ecall=1, pc=0x8000_0020 -> timer wins;
//     mcause write 0x8000_0000_0000_0007; epc=0x8000_0020.
//   - irq_timer=1 with irq_en=0, or with inst_valid=0 -> no activity.
//     Raise irq_en -> trap on the next valid instruction.
//   - ecall held high through WR_EPC/WR_CAUSE -> exactly one sequence, exactly 2 CSR writes.
//   - rst_n low during WR_CAUSE -> IDLE next cycle; no redirect.
//     Next ecall produces a full, normal sequence.

Source files
------------

// File: rtl/ysyx_220053_trap_seq_if.sv
// Signal bundle between the execute stage / CSR file and the trap sequencer.
// The master is the core side; the slave is the sequencer.
interface ysyx_220053_trap_seq_if #(
    parameter int XLEN = 64
);
    // inst_valid_i qualifies ecall_i, mret_i and interrupt acceptance; the other
    // core-side inputs are plain levels. Outputs carry no handshake and are only
    // meaningful in the cycle they are asserted.
    logic            inst_valid_i;
    logic [XLEN-1:0] pc_i;
    logic            ecall_i;
    logic            mret_i;
    logic            irq_timer_i;
    logic            irq_en_i;
    logic [XLEN-1:0] mtvec_i;
    logic [XLEN-1:0] mepc_i;
    logic            csr_wen_o;
    logic [11:0]     csr_id_o;
    logic [2:0]      csr_op_o;
    logic [XLEN-1:0] csr_data_o;
    logic            kill_o;
    logic            stall_o;
    logic            redirect_o;
    logic [XLEN-1:0] redirect_pc_o;

    modport master (
        output inst_valid_i, pc_i, ecall_i, mret_i, irq_timer_i, irq_en_i,
               mtvec_i, mepc_i,
        input  csr_wen_o, csr_id_o, csr_op_o, csr_data_o, kill_o, stall_o,
               redirect_o, redirect_pc_o
    );

    modport slave (
        input  inst_valid_i, pc_i, ecall_i, mret_i, irq_timer_i, irq_en_i,
               mtvec_i, mepc_i,
        output csr_wen_o, csr_id_o, csr_op_o, csr_data_o, kill_o, stall_o,
               redirect_o, redirect_pc_o
    );
endinterface

// File: rtl/ysyx_220053_trap_seq.sv
// Trap sequencer: serialises mepc/mcause writes through the CSR write port on
// ecall or timer interrupt, then redirects fetch to mtvec; mret redirects to mepc.
module ysyx_220053_trap_seq #(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] ECALL_CAUSE = 64'd11,
    parameter logic [XLEN-1:0] TIMER_CAUSE = 64'h8000_0000_0000_0007
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ysyx_220053_trap_seq_if.slave bus,
    output logic [1:0]            dbg_state
);
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_EPC   = 2'd1,
        WR_CAUSE = 2'd2,
        REDIR    = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] epc_q;
    logic [XLEN-1:0] cause_q;

    logic timer_evt;
    logic ecall_evt;
    logic mret_evt;
    logic take_trap;

    // Events are only looked at in IDLE; timer outranks ecall, ecall outranks mret.
    assign timer_evt = bus.inst_valid_i & bus.irq_timer_i & bus.irq_en_i;
    assign ecall_evt = bus.inst_valid_i & bus.ecall_i;
    assign mret_evt  = bus.inst_valid_i & bus.mret_i;
    assign take_trap = (state == IDLE) & (timer_evt | ecall_evt);

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            epc_q   <= '0;
            cause_q <= '0;
        end else begin
            state <= state_nxt;
            if (take_trap) begin
                epc_q   <= bus.pc_i;
                cause_q <= timer_evt ? TIMER_CAUSE : ECALL_CAUSE;
            end
        end
    end

    always_comb begin
        state_nxt         = state;
        bus.csr_wen_o     = 1'b0;
        bus.csr_id_o      = 12'h000;
        bus.csr_op_o      = 3'b000;
        bus.csr_data_o    = '0;
        bus.kill_o        = 1'b0;
        bus.stall_o       = 1'b0;
        bus.redirect_o    = 1'b0;
        bus.redirect_pc_o = '0;
        case (state)
            IDLE: begin
                if (timer_evt || ecall_evt) begin
                    bus.kill_o  = 1'b1;
                    bus.stall_o = 1'b1;
                    state_nxt   = WR_EPC;
                end else if (mret_evt) begin
                    bus.redirect_o    = 1'b1;
                    bus.redirect_pc_o = bus.mepc_i;
                end
            end
            WR_EPC: begin
                bus.csr_wen_o  = 1'b1;
                bus.csr_id_o   = CSR_MEPC;
                bus.csr_data_o = epc_q;
                bus.stall_o    = 1'b1;
                state_nxt      = WR_CAUSE;
            end
            WR_CAUSE: begin
                bus.csr_wen_o  = 1'b1;
                bus.csr_id_o   = CSR_MCAUSE;
                bus.csr_data_o = cause_q;
                bus.stall_o    = 1'b1;
                state_nxt      = REDIR;
            end
            REDIR: begin
                // Direct mode only: the mode bits of mtvec are dropped.
                bus.redirect_o    = 1'b1;
                bus.redirect_pc_o = {bus.mtvec_i[XLEN-1:2], 2'b00};
                state_nxt         = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
